regbank_wb_queue: RTL and testbench

//  Write-side driver of the register bank: buffers writeback results from the

---
 rtl/regbank_wb_queue.sv | 114 +++++++++++
 tb/tb_regbank_wb_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_queue.sv
// Purpose: writeback queue feeding the register bank's single write port, with read bypass for pending results.
// Latency: a result accepted at edge N can be written to the bank no earlier than the cycle after edge N; the bypass outputs are combinational from queue contents.
// Backpressure: res_ready drops only when the queue is full. wb_stall holds the head entry in place while accepts continue.
module regbank_wb_queue #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [AWIDTH-1:0]          res_addr,
  input  logic [DWIDTH-1:0]          res_data,
  input  logic                       wb_stall,
  output logic                       wen,
  output logic [AWIDTH-1:0]          waddr,
  output logic [DWIDTH-1:0]          wdata,
  input  logic [AWIDTH-1:0]          raddr1,
  input  logic [AWIDTH-1:0]          raddr2,
  output logic                       byp_hit1,
  output logic [DWIDTH-1:0]          byp_data1,
  output logic                       byp_hit2,
  output logic [DWIDTH-1:0]          byp_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AWIDTH-1:0] r_addr [DEPTH];
  logic [DWIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_idx;

  // Empty and full are derived from occupancy only. Ready does not depend on a same-cycle pop.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CW'(DEPTH));
    res_ready = !w_full;
    // A result for register 0 completes its handshake but is dropped, because r0 is never written.
    w_push    = res_valid && !w_full && (res_addr != '0);
    w_pop     = !w_empty && !wb_stall;
    count     = r_count;
  end

  // Present the head entry to the bank port. Outputs are zero while the queue is empty.
  always_comb begin
    wen   = w_pop;
    waddr = w_empty ? '0 : r_addr[r_rptr];
    wdata = w_empty ? '0 : r_data[r_rptr];
  end

  // Bypass scans from oldest to youngest, so the youngest match wins.
  // The head still counts as a match in the cycle it is popped.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    w_idx     = r_rptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PW'(k);
      if (r_vld[w_idx] && (raddr1 != '0) && (r_addr[w_idx] == raddr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = r_data[w_idx];
      end
      if (r_vld[w_idx] && (raddr2 != '0) && (r_addr[w_idx] == raddr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = r_data[w_idx];
      end
    end
  end

  // Queue storage, pointers and occupancy. Reset discards every pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // A push never targets the popped slot: a pop needs a non-empty queue, and a push needs a non-full one.
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_addr[r_wptr] <= res_addr;
        r_data[r_wptr] <= res_data;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr         <= r_wptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_wb_queue.sv
// Bench for regbank_wb_queue: directed scenarios followed by random traffic.
// Expected behaviour comes from an ordered list of pending writes kept in the bench.
// Outputs are sampled mid-cycle, and the model advances at each rising edge.
module tb_regbank_wb_queue;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          wb_stall;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          byp_hit1;
  logic [DW-1:0] byp_data1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data2;
  logic [CW-1:0] count;

  regbank_wb_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .wb_stall(wb_stall), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   writes_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to a nonzero address.
  task automatic model_byp(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] dat);
    hit = 1'b0;
    dat = '0;
    if (ra != '0)
      foreach (q[i])
        if (q[i].a == ra) begin
          hit = 1'b1;
          dat = q[i].d;
        end
  endtask

  // Check one cycle mid-way, then let the edge happen and update the model.
  task automatic step();
    logic          e_pop, e_push, e_full, h;
    logic [DW-1:0] d;
    ent_t          ne;
    #3;
    e_full = (q.size() == DEPTH);
    e_pop  = (q.size() != 0) && !wb_stall;
    e_push = res_valid && !e_full && (res_addr != '0);
    ne.a   = res_addr;
    ne.d   = res_data;
    chk("wen", wen, e_pop);
    if (e_pop) begin
      chk("waddr", waddr, q[0].a);
      chk("wdata", wdata, q[0].d);
      writes_seen++;
    end
    chk("res_ready", res_ready, !e_full);
    chk("count", count, q.size());
    model_byp(raddr1, h, d);
    chk("byp_hit1", byp_hit1, h);
    chk("byp_data1", byp_data1, d);
    model_byp(raddr2, h, d);
    chk("byp_hit2", byp_hit2, h);
    chk("byp_data2", byp_data2, d);
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_push) q.push_back(ne);
    #1;
  endtask

  task automatic push_step(input logic [AW-1:0] a, input logic [DW-1:0] d);
    res_valid = 1'b1;
    res_addr  = a;
    res_data  = d;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    int w0;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_addr  = '0;
    res_data  = '0;
    wb_stall  = 1'b0;
    raddr1    = 3'd3;
    raddr2    = 3'd5;
    #12;
    chk("rst_res_ready", res_ready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_byp_hit1", byp_hit1, 0);
    chk("rst_byp_data2", byp_data2, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single write, one-cycle latency
    push_step(3'd3, 8'h5A);
    #3;
    chk("t1_wen", wen, 1);
    chk("t1_waddr", waddr, 3);
    chk("t1_wdata", wdata, 8'h5A);
    #(-0);
    @(posedge clk);
    void'(q.pop_front());
    #1;
    step();
    chk("t1_count_after", count, 0);

    // 2: fill under stall, refuse a fifth push, then drain in order
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_step(AW'(i), DW'(8'h11 * i));
    #1;
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", res_ready, 0);
    chk("t2_wen_stalled", wen, 0);
    push_step(3'd6, 8'h66);
    chk("t2_count_refused", count, 4);
    wb_stall = 1'b0;
    w0 = writes_seen;
    for (int i = 0; i < 5; i++) step();
    chk("t2_drain_writes", writes_seen - w0, 4);

    // 3: bypass picks the youngest matching entry and ignores register 0
    wb_stall = 1'b1;
    push_step(3'd2, 8'hAA);
    push_step(3'd5, 8'h01);
    push_step(3'd2, 8'hBB);
    raddr1 = 3'd2;
    raddr2 = 3'd5;
    #1;
    chk("t3_hit1", byp_hit1, 1);
    chk("t3_data1", byp_data1, 8'hBB);
    chk("t3_hit2", byp_hit2, 1);
    chk("t3_data2", byp_data2, 8'h01);
    raddr1 = 3'd0;
    #1;
    chk("t3_hit1_r0", byp_hit1, 0);
    chk("t3_data1_r0", byp_data1, 0);
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // 4: a write to register 0 handshakes but is never queued
    w0 = writes_seen;
    push_step(3'd0, 8'hFF);
    chk("t4_count", count, 0);
    step();
    chk("t4_no_write", writes_seen - w0, 0);

    // 5: reset in the middle of a drain
    wb_stall = 1'b1;
    push_step(3'd1, 8'hA1);
    push_step(3'd4, 8'hA4);
    push_step(3'd7, 8'hA7);
    raddr1 = 3'd4;
    raddr2 = 3'd7;
    wb_stall = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_wen_rst", wen, 0);
    chk("t5_count_rst", count, 0);
    chk("t5_hit1_rst", byp_hit1, 0);
    chk("t5_hit2_rst", byp_hit2, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = writes_seen;
    for (int i = 0; i < 4; i++) step();
    chk("t5_no_stale", writes_seen - w0, 0);

    // 6: sustained push and pop, with pointer wrap
    w0 = writes_seen;
    for (int i = 0; i < 10; i++) begin
      push_step(AW'(1 + (i % 7)), DW'(8'h30 + i));
      if (i > 0) chk("t6_count_steady", count, 1);
    end
    step();
    chk("t6_writes", writes_seen - w0, 10);
    chk("t6_empty", count, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      res_valid = ($urandom_range(0, 3) != 0);
      res_addr  = AW'($urandom);
      res_data  = DW'($urandom);
      wb_stall  = ($urandom_range(0, 2) == 0);
      raddr1    = AW'($urandom);
      raddr2    = AW'($urandom);
      step();
    end
    res_valid = 1'b0;
    wb_stall  = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) step();
    chk("final_empty", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
